// File: rtl/ifht_pkg.sv
// Shared constants and FSM encoding for the 8-point Hadamard transform datapath.
package ifht_pkg;
  localparam int NPT    = 8;
  localparam int NSTAGE = 3;
  localparam int SHIFT  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ifht_8pt_cg_stage.sv
// One constant-geometry Hadamard butterfly stage, combinational, NPT lanes.
// Lanes are fed in pairs and the sums and differences are written to split halves.
module fht_cg_stage
  import ifht_pkg::*;
#(
  parameter int IW = 14
) (
  input  logic [NPT-1:0][IW-1:0] w,
  output logic [NPT-1:0][IW-1:0] y
);
  // The accumulator width is chosen so that no stage can wrap.
  for (genvar k = 0; k < NPT/2; k++) begin : g_bfly
    assign y[k]       = w[2*k] + w[2*k+1];
    assign y[k+NPT/2] = w[2*k] - w[2*k+1];
  end
endmodule

// File: rtl/ifht_8pt.sv
// Iterative inverse 8-point FHT, x = (H8*X)/8, with valid/ready on both sides.
// Define IFHT_SAT_EN to clamp the outputs and add the sat_o port. By default the outputs wrap.
module ifht_8pt
  import ifht_pkg::*;
#(
  parameter  int DW = 8,
  localparam int CW = DW + 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NPT*CW-1:0] coef_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NPT*DW-1:0] data_o,
  output logic            busy
`ifdef IFHT_SAT_EN
  ,
  output logic            sat_o
`endif
);
  localparam int IW = DW + 6;

  state_e                  state;
  logic [1:0]              cnt;
  logic [NPT-1:0][IW-1:0]  w;
  logic [NPT-1:0][IW-1:0]  w_nxt;

  fht_cg_stage #(.IW(IW)) u_stage (.w(w), .y(w_nxt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      w     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int k = 0; k < NPT; k++)
            w[k] <= {{(IW-CW){coef_i[k*CW+CW-1]}}, coef_i[k*CW +: CW]};
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          w   <= w_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(NSTAGE-1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

`ifdef IFHT_SAT_EN
  localparam int SW = IW - SHIFT;
  localparam logic signed [SW-1:0] SMAX = SW'((2**(DW-1)) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2**(DW-1)));
  logic [NPT-1:0] clip;

  for (genvar k = 0; k < NPT; k++) begin : g_lane
    // Dropping the low SHIFT bits is an arithmetic shift that rounds toward -inf.
    logic signed [SW-1:0] sh;
    assign sh      = w[k][IW-1:SHIFT];
    assign clip[k] = (sh > SMAX) || (sh < SMIN);
    assign data_o[k*DW +: DW] = (sh > SMAX) ? SMAX[DW-1:0] :
                                (sh < SMIN) ? SMIN[DW-1:0] : sh[DW-1:0];
  end
  assign sat_o = (state == DONE) && (|clip);
`else
  for (genvar k = 0; k < NPT; k++) begin : g_lane
    assign data_o[k*DW +: DW] = w[k][SHIFT+DW-1:SHIFT];
  end
`endif
endmodule

// File: tb/tb_ifht_8pt.sv
// Scoreboard bench for ifht_8pt. The expected values come from a direct H8 matrix product.
// The bench also works when IFHT_SAT_EN is defined.
module tb_ifht_8pt;
  localparam int DW  = 8;
  localparam int CW  = DW + 3;
  localparam int NPT = 8;

  logic                clk, reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [NPT*CW-1:0]   coef_i;
  logic [NPT*DW-1:0]   data_o;
`ifdef IFHT_SAT_EN
  logic                sat_o;
`endif

  ifht_8pt #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .coef_i(coef_i), .out_valid(out_valid), .out_ready(out_ready),
    .data_o(data_o), .busy(busy)
`ifdef IFHT_SAT_EN
    , .sat_o(sat_o)
`endif
  );

  typedef struct {
    logic [NPT*DW-1:0] d;
    logic              s;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: x[n] = floor(sum_k (-1)^popcount(n&k) * c[k] / 8), then wrap or clamp.
  function automatic exp_t ref_ifht(input int c[8]);
    exp_t e;
    int   acc, v;
    e.d = '0;
    e.s = 1'b0;
    for (int n = 0; n < NPT; n++) begin
      acc = 0;
      for (int k = 0; k < NPT; k++)
        acc += ($countones(n & k) % 2 == 1) ? -c[k] : c[k];
      v = acc >>> 3;
`ifdef IFHT_SAT_EN
      if (v > 127)  begin v = 127;  e.s = 1'b1; end
      if (v < -128) begin v = -128; e.s = 1'b1; end
`endif
      e.d[n*DW +: DW] = v[DW-1:0];
    end
    return e;
  endfunction

  function automatic logic [NPT*CW-1:0] pack(input int c[8]);
    logic [NPT*CW-1:0] p;
    int t;
    for (int k = 0; k < NPT; k++) begin
      t = c[k];
      p[k*CW +: CW] = t[CW-1:0];
    end
    return p;
  endfunction

  task automatic send(input int c[8], input bit push);
    int t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    coef_i   = pack(c);
    in_valid = 1'b1;
    if (push) q.push_back(ref_ifht(c));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // The round-trip expectation is the original sample vector itself, not the model output.
  task automatic send_rt(input int x[8]);
    int   c[8];
    exp_t e;
    for (int k = 0; k < NPT; k++) begin
      c[k] = 0;
      for (int n = 0; n < NPT; n++)
        c[k] += ($countones(n & k) % 2 == 1) ? -x[n] : x[n];
    end
    send(c, 1'b0);
    e.s = 1'b0;
    for (int n = 0; n < NPT; n++) e.d[n*DW +: DW] = x[n][DW-1:0];
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !in_ready) && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("data_o", data_o, e.d);
`ifdef IFHT_SAT_EN
        chk("sat_o", sat_o, e.s);
`endif
      end
    end
  end

  initial begin
    int c[8], x[8], c2[8];
    logic [NPT*DW-1:0] snap;
    int t;
    reset = 0; in_valid = 0; out_ready = 1; coef_i = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_o", data_o, 0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // DC with latency check
    c = '{80, 0, 0, 0, 0, 0, 0, 0};
    send(c, 1'b1);
    @(posedge clk); #1; chk("lat_t1", out_valid, 0);
    chk("run_in_ready", in_ready, 0);
    @(posedge clk); #1; chk("lat_t2", out_valid, 0);
    @(posedge clk); #1; chk("lat_t3", out_valid, 1);
    chk("done_busy", busy, 1);
    drain();

    // Impulses, negative full scale, overflow, single-bin sign pattern
    c = '{1, 1, 1, 1, 1, 1, 1, 1};           send(c, 1'b1);
    c = '{8, 8, 8, 8, 8, 8, 8, 8};           send(c, 1'b1);
    c = '{-1024, 0, 0, 0, 0, 0, 0, 0};       send(c, 1'b1);
    c = '{1023, 1023, 0, 0, 0, 0, 0, 0};     send(c, 1'b1);
    c = '{0, 64, 0, 0, 0, 0, 0, 0};          send(c, 1'b1);
    c = '{0, 0, 0, 0, 0, 0, 0, -8};          send(c, 1'b1);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NPT; k++) c[k] = int'($urandom_range(0, 2047)) - 1024;
      send(c, 1'b1);
    end
    drain();

    // Backpressure: hold the output and ignore a new request while busy
    out_ready = 0;
    c = '{40, -16, 24, 8, 0, 0, -32, 8};
    send(c, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("bp_out_valid", out_valid, 1);
    snap = data_o;
    c2 = '{8, 8, 8, 8, 8, 8, 8, 8};
    coef_i = pack(c2); in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", data_o, snap);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    drain();

    // Round trip of random 8-bit samples, including the extremes
    x = '{-128, 127, -128, 127, 0, -1, 1, -128};
    send_rt(x);
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < NPT; n++) x[n] = int'($urandom_range(0, 255)) - 128;
      send_rt(x);
    end
    drain();

    // Reset in RUN discards the vector
    c = '{80, 0, 0, 0, 0, 0, 0, 0};
    send(c, 1'b0);
    @(posedge clk); #1;
    reset = 0; #3;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    repeat (5) begin @(posedge clk); #1; chk("midrst_no_out", out_valid, 0); end
    c = '{-24, 8, 0, 16, 0, 0, 0, 0};
    send(c, 1'b1);
    drain();

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
